// File: rtl/pattern_sequencer.sv
// Frame-synchronous colour-pattern mode sequencer: advances the pattern on a
// debounced button press or after a fixed number of frames, only at frame start.
module pattern_sequencer #(
    parameter int FRAMES_PER_MODE = 60,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int NUM_MODES       = 4
) (
    input  logic       clk_25,
    input  logic       n_rst,
    input  logic       vsync,
    input  logic       video_on,
    input  logic       btn_next,
    input  logic       auto_en,
    output logic [1:0] mode,
    output logic       mode_valid,
    output logic       pixel_enable,
    output logic       frame_tick
);
    localparam logic [0:0] WAIT_FRAME = 1'b0;
    localparam logic [0:0] RUN        = 1'b1;

    localparam int FC_W = $clog2(FRAMES_PER_MODE) + 1;
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [FC_W-1:0] FC_LAST   = FC_W'(FRAMES_PER_MODE - 1);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]      MODE_LAST = 2'(NUM_MODES - 1);

    logic [0:0]      r_state;
    logic            r_vsync_d;
    logic            r_frame_tick;
    logic            r_btn_meta;
    logic            r_btn_sync;
    logic            r_btn_db;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_pending;
    logic [FC_W-1:0] r_frame_cnt;
    logic [1:0]      r_mode;

    logic w_frame_start;
    logic w_run;
    logic w_db_flip;
    logic w_db_rise;
    logic w_expire;
    logic w_advance;

    assign w_frame_start = !vsync && r_vsync_d;
    assign w_run         = (r_state == RUN);
    // The rise is taken on the cycle the debounced level is about to flip so a
    // press landing on a frame-start cycle is applied at that frame start.
    assign w_db_flip     = (r_btn_sync != r_btn_db) && (r_db_cnt == DB_LAST);
    assign w_db_rise     = w_db_flip && r_btn_sync;
    assign w_expire      = auto_en && (r_frame_cnt == FC_LAST);
    assign w_advance     = w_frame_start && w_run && (r_pending || w_db_rise || w_expire);

    always_ff @(posedge clk_25 or negedge n_rst) begin
        if (!n_rst) begin
            r_vsync_d    <= 1'b1;
            r_frame_tick <= 1'b0;
            r_state      <= WAIT_FRAME;
        end else begin
            r_vsync_d    <= vsync;
            r_frame_tick <= w_frame_start;
            if (w_frame_start)
                r_state <= RUN;
        end
    end

    always_ff @(posedge clk_25 or negedge n_rst) begin
        if (!n_rst) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_btn_db   <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_btn_meta <= btn_next;
            r_btn_sync <= r_btn_meta;
            if (r_btn_sync == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (w_db_flip) begin
                r_db_cnt <= '0;
                r_btn_db <= r_btn_sync;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_25 or negedge n_rst) begin
        if (!n_rst) begin
            r_pending   <= 1'b0;
            r_frame_cnt <= '0;
            r_mode      <= 2'd0;
        end else begin
            if (w_advance)
                r_pending <= 1'b0;
            else if (w_db_rise)
                r_pending <= 1'b1;

            if (!auto_en || w_advance)
                r_frame_cnt <= '0;
            else if (w_frame_start && w_run)
                r_frame_cnt <= r_frame_cnt + 1'b1;

            if (w_advance)
                r_mode <= (r_mode == MODE_LAST) ? 2'd0 : r_mode + 2'd1;
        end
    end

    assign mode         = r_mode;
    assign mode_valid   = w_run;
    assign pixel_enable = video_on && w_run;
    assign frame_tick   = r_frame_tick;
endmodule

// File: tb/tb_pattern_sequencer.sv
// Scoreboard bench for pattern_sequencer: expected modes are queued when a frame
// start is driven and compared against the mode captured on each frame_tick.
module tb_pattern_sequencer;
    localparam int FPM = 3;
    localparam int DBC = 4;
    localparam int NM  = 4;

    logic       clk_25   = 1'b0;
    logic       n_rst    = 1'b0;
    logic       vsync    = 1'b1;
    logic       video_on = 1'b0;
    logic       btn_next = 1'b0;
    logic       auto_en  = 1'b0;
    logic [1:0] mode;
    logic       mode_valid;
    logic       pixel_enable;
    logic       frame_tick;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];

    pattern_sequencer #(
        .FRAMES_PER_MODE(FPM),
        .DEBOUNCE_CYCLES(DBC),
        .NUM_MODES      (NM)
    ) dut (
        .clk_25      (clk_25),
        .n_rst       (n_rst),
        .vsync       (vsync),
        .video_on    (video_on),
        .btn_next    (btn_next),
        .auto_en     (auto_en),
        .mode        (mode),
        .mode_valid  (mode_valid),
        .pixel_enable(pixel_enable),
        .frame_tick  (frame_tick)
    );

    always #20 clk_25 = ~clk_25;

    always @(negedge clk_25)
        if (frame_tick) obs_q.push_back(mode);

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_25);
        #1;
    endtask

    task automatic frame_start(input logic [1:0] exp_mode);
        exp_q.push_back(exp_mode);
        tick(1);
        vsync = 1'b0;
        tick(1);
        vsync = 1'b1;
        tick(8);
    endtask

    task automatic press(input int cycles);
        tick(1);
        btn_next = 1'b1;
        tick(cycles);
        btn_next = 1'b0;
        tick(10);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        tick(3);
        n_rst = 1'b1;
        tick(2);
    endtask

    task automatic test_reset();
        logic [1:0] e, o;
        video_on = 1'b1;
        #5;
        n_checks++;
        if ({mode, mode_valid, pixel_enable, frame_tick} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_hold: mode=%0d mv=%b pe=%b ft=%b, required all 0", mode, mode_valid, pixel_enable, frame_tick);
        end
        tick(3);
        n_rst = 1'b1;
        tick(5);
        n_checks++;
        if (pixel_enable !== 1'b0 || mode_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL wait_frame: pe=%b mv=%b, required 0 0", pixel_enable, mode_valid);
        end
        exp_q.push_back(2'd0);
        vsync = 1'b0;
        @(negedge clk_25);
        n_checks++;
        if (frame_tick !== 1'b0 || mode_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL tick_latency: ft=%b mv=%b on detect cycle, required 0 0", frame_tick, mode_valid);
        end
        @(negedge clk_25);
        n_checks++;
        if (frame_tick !== 1'b1 || mode_valid !== 1'b1 || pixel_enable !== 1'b1) begin
            n_errors++;
            $display("FAIL first_frame: ft=%b mv=%b pe=%b, required 1 1 1", frame_tick, mode_valid, pixel_enable);
        end
        @(negedge clk_25);
        n_checks++;
        if (frame_tick !== 1'b0) begin
            n_errors++;
            $display("FAIL tick_width: ft=%b with vsync held low, required 0", frame_tick);
        end
        video_on = 1'b0;
        #1;
        n_checks++;
        if (pixel_enable !== 1'b0) begin
            n_errors++;
            $display("FAIL pe_follow: pe=%b with video_on=0, required 0", pixel_enable);
        end
        video_on = 1'b1;
        tick(2);
        vsync = 1'b1;
        tick(5);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_errors++;
                $display("FAIL reset_sb: no frame_tick, expected mode %0d", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_errors++;
                    $display("FAIL reset_sb: mode %0d, expected %0d", o, e);
                end
            end
        end
    endtask

    task automatic test_auto();
        logic [1:0] e, o;
        logic [1:0] seq[13] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                                2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
        auto_en = 1'b1;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            frame_start(seq[i]);
            n_checks++;
            if (mode !== seq[i]) begin
                n_errors++;
                $display("FAIL auto_mid: frame %0d mode %0d, expected %0d", i, mode, seq[i]);
            end
        end
        auto_en = 1'b0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_errors++;
                $display("FAIL auto_sb: no frame_tick, expected mode %0d", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_errors++;
                    $display("FAIL auto_sb: mode %0d, expected %0d", o, e);
                end
            end
        end
    endtask

    task automatic test_debounce();
        logic [1:0] e, o;
        press(3);
        frame_start(2'd0);
        tick(1);
        btn_next = 1'b1;
        tick(3);
        btn_next = 1'b0;
        tick(1);
        btn_next = 1'b1;
        tick(3);
        btn_next = 1'b0;
        tick(10);
        frame_start(2'd0);
        press(6);
        n_checks++;
        if (mode !== 2'd0) begin
            n_errors++;
            $display("FAIL debounce_early: mode %0d before frame start, expected 0", mode);
        end
        frame_start(2'd1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_errors++;
                $display("FAIL debounce_sb: no frame_tick, expected mode %0d", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_errors++;
                    $display("FAIL debounce_sb: mode %0d, expected %0d", o, e);
                end
            end
        end
    endtask

    task automatic test_multi_press();
        logic [1:0] e, o;
        press(6);
        press(6);
        press(6);
        n_checks++;
        if (mode !== 2'd1) begin
            n_errors++;
            $display("FAIL multi_early: mode %0d mid-frame, expected 1", mode);
        end
        frame_start(2'd2);
        frame_start(2'd2);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_errors++;
                $display("FAIL multi_sb: no frame_tick, expected mode %0d", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_errors++;
                    $display("FAIL multi_sb: mode %0d, expected %0d", o, e);
                end
            end
        end
    endtask

    task automatic test_coincide();
        logic [1:0] e, o;
        // Debounced rise and frame start sampled on the same clock edge.
        tick(1);
        btn_next = 1'b1;
        tick(5);
        vsync = 1'b0;
        exp_q.push_back(2'd3);
        tick(1);
        vsync = 1'b1;
        btn_next = 1'b0;
        tick(12);
        auto_en = 1'b1;
        frame_start(2'd3);
        frame_start(2'd3);
        tick(1);
        btn_next = 1'b1;
        tick(5);
        vsync = 1'b0;
        exp_q.push_back(2'd0);
        tick(1);
        vsync = 1'b1;
        btn_next = 1'b0;
        tick(12);
        frame_start(2'd0);
        frame_start(2'd0);
        frame_start(2'd1);
        auto_en = 1'b0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_errors++;
                $display("FAIL coincide_sb: no frame_tick, expected mode %0d", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_errors++;
                    $display("FAIL coincide_sb: mode %0d, expected %0d", o, e);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [1:0] e, o;
        do_reset();
        frame_start(2'd0);
        press(6);
        frame_start(2'd1);
        press(6);
        frame_start(2'd2);
        video_on = 1'b1;
        #7;
        n_rst = 1'b0;
        #1;
        n_checks++;
        if ({mode, mode_valid, pixel_enable, frame_tick} !== 5'b0) begin
            n_errors++;
            $display("FAIL midframe_reset: mode=%0d mv=%b pe=%b ft=%b, required all 0", mode, mode_valid, pixel_enable, frame_tick);
        end
        tick(3);
        n_rst = 1'b1;
        press(6);
        n_checks++;
        if (pixel_enable !== 1'b0 || mode_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_pe: pe=%b mv=%b before frame start, required 0 0", pixel_enable, mode_valid);
        end
        frame_start(2'd0);
        n_checks++;
        if (pixel_enable !== 1'b1) begin
            n_errors++;
            $display("FAIL post_reset_run: pe=%b after frame start, required 1", pixel_enable);
        end
        frame_start(2'd1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_errors++;
                $display("FAIL midreset_sb: no frame_tick, expected mode %0d", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_errors++;
                    $display("FAIL midreset_sb: mode %0d, expected %0d", o, e);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_errors++;
            $display("FAIL extra_ticks: %0d unexpected frame_tick pulses, required 0", obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_auto();
        test_debounce();
        test_multi_press();
        test_coincide();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 The block SHALL have parameter FRAMES_PER_MODE, default 60, giving the frames shown per mode in auto mode.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000 (10 ms at 25 MHz), giving the button stable-time.
REQ-003 The block SHALL have parameter NUM_MODES, default 4, giving the mode count (2..4).
REQ-004 The block SHALL have port clk_25  input  1  the 25 MHz pixel clock, the block's only clock.
REQ-005 The block SHALL have port n_rst  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port vsync  input  1  active-low vertical sync from vga_controller, synchronous to clk_25.
REQ-007 The block SHALL have port video_on  input  1  active-display flag from vga_controller.
REQ-008 The block SHALL have port btn_next  input  1  raw active-high pushbutton, asynchronous to clk_25.
REQ-009 The block SHALL have port auto_en  input  1  enables timed mode advance; synchronous to clk_25.
REQ-010 The block SHALL have port mode  output  2  colour-pattern select for the pixel datapath.
REQ-011 The block SHALL have port mode_valid  output  1  high when mode is active and stable.
REQ-012 The block SHALL have port pixel_enable  output  1  load_enable for the colour datapath.
REQ-013 The block SHALL have port frame_tick  output  1  one-cycle pulse per frame start.

Function
REQ-014 Frame start SHALL be detected as vsync sampled low in the current cycle while high in the previous registered sample.
REQ-015 frame_tick SHALL be registered, asserting for exactly one cycle, the cycle after the frame-start detection.
REQ-016 The FSM SHALL have two states: WAIT_FRAME (entered on reset) and RUN.
REQ-017 The FSM SHALL move from WAIT_FRAME to RUN on the first frame start and SHALL never leave RUN except by reset.
REQ-018 mode_valid SHALL be 1 in RUN and 0 in WAIT_FRAME.
REQ-019 pixel_enable SHALL equal video_on AND (state == RUN), combinationally, with zero latency.
REQ-020 btn_next SHALL pass through a 2-flop synchronizer before any other use.
REQ-021 The debounced button level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
- Any shorter glitch SHALL reset the stability counter.
REQ-022 A 0->1 transition of the debounced level SHALL set a pending_next flag.
REQ-023 When auto_en=1 in RUN, a frame counter SHALL increment on each frame start.
REQ-024 The frame counter SHALL raise auto-expiry at the frame start on which the counter equals FRAMES_PER_MODE-1.
REQ-025 When auto_en=0, the frame counter SHALL be held at 0.
REQ-026 mode SHALL change only on a frame-start cycle, in RUN, and only if pending_next or auto-expiry is true; the next mode SHALL be (mode+1) mod NUM_MODES.
- The wrap from NUM_MODES-1 to 0 is included.
REQ-027 Every mode change SHALL clear pending_next and the frame counter in the same cycle.
REQ-028 If pending_next and auto-expiry coincide, mode SHALL advance by exactly one.
REQ-029 A debounced rising edge in the same cycle as a frame start SHALL be applied at that frame start.
REQ-030 Multiple button presses between frame starts SHALL collapse into a single advance.
REQ-031 Button presses during WAIT_FRAME SHALL set pending_next.
- The first frame start only enters RUN; the pending press SHALL be applied at the second frame start.
REQ-032 No mode change SHALL ever occur mid-frame.

Reset
REQ-033 While n_rst=0, regardless of clock, the block SHALL hold: state WAIT_FRAME, mode 0, mode_valid 0, frame_tick 0, pixel_enable 0.
REQ-034 While n_rst=0, the block SHALL also hold frame counter 0, pending_next 0, debounced level 0, synchronizer and vsync registers cleared.
- The vsync register SHALL be cleared to 1, i.e. inactive.
REQ-035 Reset deassertion mid-frame SHALL suppress pixel_enable until the next frame start; the first frame start then starts the mode at 0.

Verification (FRAMES_PER_MODE=3, DEBOUNCE_CYCLES=4, NUM_MODES=4)
REQ-036 Reset, video_on=1, no vsync edge -> pixel_enable=0 and mode_valid=0; first vsync fall -> frame_tick one cycle later, mode_valid=1, pixel_enable follows video_on.
REQ-037 auto_en=1, 13 frame starts after entering RUN -> mode sequence 0,0,0,1,1,1,2,2,2,3,3,3,0.
- Each change SHALL land exactly on a frame-start cycle.
REQ-038 btn_next pulse of 3 cycles -> no advance; btn_next held 6 cycles -> mode 0->1 at the next frame start, not before.
REQ-039 Three valid presses within one frame, auto_en=0 -> mode advances by exactly 1 at the next frame start.
REQ-040 auto_en=1, press debounced on the frame where auto-expiry fires -> single advance (e.g. 1->2), frame counter 0 afterward.
REQ-041 n_rst asserted at mode=2 mid-frame -> mode=0 and all outputs 0 immediately.
- After release, pixel_enable SHALL stay 0 until the next vsync fall.
